three_bcd_divider_checker: RTL and testbench

Sequential checker that decides whether a single BCD digit `d` divides the three-digit BCD number `a b c` (`a` = hundreds, `b` = tens, `c` = units). It processes one digit per clock using remainder-propagation arithmetic. It reports the result with a one-cycle `done` strobe and holds it until the next request. It sits as a leaf arithmetic block behind a simple start/done handshake.

---
 rtl/three_bcd_divider_checker_pkg.sv | 25 ++
 rtl/three_bcd_divider_checker_if.sv | 29 ++
 rtl/three_bcd_divider_checker_mod_step.sv | 31 +++
 rtl/three_bcd_divider_checker.sv | 99 +++++++++
 tb/tb_three_bcd_divider_checker.sv | 131 +++++++++++++
 5 files changed

// File: rtl/three_bcd_divider_checker_pkg.sv
// Shared definitions for the three-digit BCD divisibility checker.
//   state_e  : FSM encoding, one state per processed digit plus IDLE.
//   BCD_MAX  : largest legal BCD digit value.
//   DIGIT_W  : width of one BCD digit.
//   ACC_W    : width of the r*10 + digit intermediate (max 89).
//   isBcd()  : legality test for a single digit.
package bcd_div_pkg;

  localparam int BCD_MAX = 9;
  localparam int DIGIT_W = 4;
  localparam int ACC_W   = 7;

  // Explicit encodings keep the state values stable for legacy tooling.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUND = 2'd1,
    TENS = 2'd2,
    UNIT = 2'd3
  } state_e;

  function automatic logic isBcd(input logic [DIGIT_W-1:0] v);
    return v <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/three_bcd_divider_checker_if.sv
// Start/done handshake and operand/result bundle of the BCD divisibility
// checker.
//   master : requester drives start, a, b, c, d; observes the results.
//   slave  : checker samples the request; drives busy, done, isDivider,
//            invalid.
interface three_bcd_divider_checker_if;
  import bcd_div_pkg::*;

  logic               start;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic [DIGIT_W-1:0] c;
  logic [DIGIT_W-1:0] d;
  logic               busy;
  logic               done;
  logic               isDivider;
  logic               invalid;

  modport master (
    output start, a, b, c, d,
    input  busy, done, isDivider, invalid
  );

  modport slave (
    input  start, a, b, c, d,
    output busy, done, isDivider, invalid
  );

endinterface

// File: rtl/three_bcd_divider_checker_mod_step.sv
// One remainder-propagation step: rem = (r*10 + digit) mod d.
//   r     : incoming remainder, r < d for legal operands.
//   digit : next BCD digit of the dividend.
//   d     : BCD divisor; the result is meaningless for d = 0.
//   rem   : outgoing remainder.
// With r <= d-1 and digit <= 9 the accumulator never exceeds 10*d - 1, so
// BCD_MAX conditional subtractions always bring it below d.
module bcd_mod_step
  import bcd_div_pkg::*;
(
  input  logic [DIGIT_W-1:0] r,
  input  logic [DIGIT_W-1:0] digit,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] rem
);

  logic [ACC_W-1:0] acc;

  // NOTE: every variable written here gets a value before any branch, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    acc = ACC_W'(r) * ACC_W'(10) + ACC_W'(digit);
    for (int i = 0; i < BCD_MAX; i++) begin
      if (d != '0 && acc >= ACC_W'(d)) begin
        acc = acc - ACC_W'(d);
      end
    end
    rem = acc[DIGIT_W-1:0];
  end

endmodule

// File: rtl/three_bcd_divider_checker.sv
// Sequential check of whether BCD digit d divides the BCD number abc,
// one digit per clock (hundreds, tens, units).
//   clk   : rising-edge clock.
//   rst_n : asynchronous active-low reset.
//   bus   : slave side of the start/done handshake. A start seen in IDLE
//           registers the operands; done pulses for one cycle three edges
//           later with isDivider/invalid, which then hold until the next
//           accepted start.
module three_bcd_divider_checker
  import bcd_div_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  three_bcd_divider_checker_if.slave    bus
);

  state_e             state;
  logic [DIGIT_W-1:0] opA, opB, opC, opD;
  logic [DIGIT_W-1:0] rem;
  logic               invalidOp;

  logic [DIGIT_W-1:0] digit;
  logic [DIGIT_W-1:0] stepOut;
  logic [DIGIT_W-1:0] remNext;

  always_comb begin
    unique case (state)
      HUND:    digit = opA;
      TENS:    digit = opB;
      default: digit = opC;
    endcase
  end

  bcd_mod_step uStep (
    .r     (rem),
    .digit (digit),
    .d     (opD),
    .rem   (stepOut)
  );

  // Illegal operands still walk every state for identical latency, but the
  // step result is discarded so the remainder never leaves its legal range.
  assign remNext = invalidOp ? '0 : stepOut;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      opA           <= '0;
      opB           <= '0;
      opC           <= '0;
      opD           <= '0;
      rem           <= '0;
      invalidOp     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.isDivider <= 1'b0;
      bus.invalid   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            opA           <= bus.a;
            opB           <= bus.b;
            opC           <= bus.c;
            opD           <= bus.d;
            invalidOp     <= (bus.d == '0) || !isBcd(bus.a) || !isBcd(bus.b)
                             || !isBcd(bus.c) || !isBcd(bus.d);
            rem           <= '0;
            bus.busy      <= 1'b1;
            bus.isDivider <= 1'b0;
            bus.invalid   <= 1'b0;
            state         <= HUND;
          end
        end
        HUND: begin
          rem   <= remNext;
          state <= TENS;
        end
        TENS: begin
          rem   <= remNext;
          state <= UNIT;
        end
        UNIT: begin
          rem           <= remNext;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b1;
          bus.invalid   <= invalidOp;
          bus.isDivider <= !invalidOp && (stepOut == '0);
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_three_bcd_divider_checker.sv
// Directed self-checking bench for three_bcd_divider_checker.
module tb_three_bcd_divider_checker;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   doneCount;

  three_bcd_divider_checker_if bus ();

  three_bcd_divider_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done is one cycle wide, so sampling on the falling edge counts each
  // pulse exactly once.
  always @(negedge clk) begin
    if (bus.done === 1'b1) doneCount++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutputs(input string tag, input logic expBusy,
                              input logic expDone, input logic expDiv,
                              input logic expInv);
    check({tag, "_busy"},      32'(bus.busy),      32'(expBusy));
    check({tag, "_done"},      32'(bus.done),      32'(expDone));
    check({tag, "_isDivider"}, 32'(bus.isDivider), 32'(expDiv));
    check({tag, "_invalid"},   32'(bus.invalid),   32'(expInv));
  endtask

  // Called 1 time unit after a rising edge. Start is sampled at the next
  // edge (N); the result must appear right after edge N+3 for one cycle.
  task automatic runOp(input string tag, input logic [3:0] ia,
                       input logic [3:0] ib, input logic [3:0] ic,
                       input logic [3:0] id, input logic expDiv,
                       input logic expInv);
    bus.start = 1'b1;
    bus.a = ia; bus.b = ib; bus.c = ic; bus.d = id;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // Scramble live operands: only the registered copies may matter.
    bus.a = 4'hF; bus.b = 4'hE; bus.c = 4'hD; bus.d = 4'h0;
    checkOutputs({tag, "_accept"}, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    checkOutputs({tag, "_n2"}, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutputs({tag, "_result"}, 1'b0, 1'b1, expDiv, expInv);
    @(posedge clk); #1;
    checkOutputs({tag, "_hold"}, 1'b0, 1'b0, expDiv, expInv);
  endtask

  int doneBefore;

  initial begin
    checks    = 0;
    errors    = 0;
    doneCount = 0;
    bus.start = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    rst_n = 1'b0;

    // Reset state.
    #12;
    checkOutputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutputs("idle5", 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed vectors.
    runOp("div0_040",  4'd0, 4'd4, 4'd0, 4'd0, 1'b0, 1'b1);
    runOp("999_by9",   4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0);
    runOp("100_by7",   4'd1, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
    runOp("840_by8",   4'd8, 4'd4, 4'd0, 4'd8, 1'b1, 1'b0);
    runOp("000_by3",   4'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
    runOp("A00_by1",   4'hA, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);
    runOp("126_by7",   4'd1, 4'd2, 4'd6, 4'd7, 1'b1, 1'b0);
    runOp("500_by6",   4'd5, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0);
    runOp("09C_by3",   4'd0, 4'd9, 4'hC, 4'd3, 1'b0, 1'b1);

    // start held high during busy with other operands must be ignored.
    doneBefore = doneCount;
    bus.start = 1'b1;
    bus.a = 4'd2; bus.b = 4'd5; bus.c = 4'd2; bus.d = 4'd4;  // 252 = 4*63
    @(posedge clk); #1;
    bus.a = 4'd1; bus.b = 4'd0; bus.c = 4'd1; bus.d = 4'd2;  // 101, odd
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutputs("busyStart_result", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("busyStart_doneCount", 32'(doneCount - doneBefore), 32'd1);
    checkOutputs("busyStart_hold", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during TENS abandons the computation without a done pulse.
    doneBefore = doneCount;
    bus.start = 1'b1;
    bus.a = 4'd9; bus.b = 4'd9; bus.c = 4'd9; bus.d = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutputs("midReset", 1'b0, 1'b0, 1'b0, 1'b0);
    #10;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midReset_noDone", 32'(doneCount - doneBefore), 32'd0);
    checkOutputs("midReset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    runOp("post_369_by3", 4'd3, 4'd6, 4'd9, 4'd3, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
